// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register: owns the PC, keeps one fetch in flight, and has a one-entry skid buffer.
// Define FETCH_PERF_CNT_EN to add the saturating perf_fetched_o/perf_stall_o counters.
module fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int INSTR_BYTES = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  input  logic redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic imem_ready_i,
  input  logic imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic if_id_valid_o,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic [ADDR_W-1:0] if_id_pc_o,
  output logic [2:0] opcode_o,
  output logic [1:0] funct2_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, SKID} state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN = ~(ADDR_W'(INSTR_BYTES - 1));

  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic drop, drop_n;
  logic cap, fill, load, free;
  logic [INSTR_W-1:0] load_instr;
  logic [ADDR_W-1:0] load_pc;

  assign free = !if_id_valid_o || !stall_i;

  always_comb begin
    state_n = state;
    pc_n = pc;
    drop_n = drop;
    cap = 1'b0;
    fill = 1'b0;
    load = 1'b0;
    load_instr = imem_rdata_i;
    load_pc = fetch_pc;
    if (redirect_i) begin
      pc_n = redirect_pc_i & ALIGN;
      state_n = REQ;
      drop_n = 1'b0;
      // an accepted or still-pending old fetch must be dropped on return
      unique case (state)
        REQ: begin
          if (imem_ready_i) begin
            state_n = WAIT;
            drop_n = 1'b1;
          end
        end
        WAIT: begin
          if (!imem_rvalid_i) begin
            state_n = WAIT;
            drop_n = 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      unique case (state)
        IDLE: state_n = REQ;
        REQ: begin
          if (imem_ready_i) begin
            pc_n = pc + STEP;
            cap = 1'b1;
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (drop) begin
              drop_n = 1'b0;
              state_n = REQ;
            end else if (free) begin
              load = 1'b1;
              state_n = REQ;
            end else begin
              fill = 1'b1;
              state_n = SKID;
            end
          end
        end
        SKID: begin
          if (!stall_i) begin
            load = 1'b1;
            load_instr = skid_instr;
            load_pc = skid_pc;
            state_n = REQ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      drop <= 1'b0;
      fetch_pc <= '0;
      skid_pc <= '0;
      skid_instr <= NOP_INSTR;
    end else begin
      state <= state_n;
      pc <= pc_n;
      drop <= drop_n;
      if (cap) fetch_pc <= pc;
      if (fill) begin
        skid_pc <= fetch_pc;
        skid_instr <= imem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= NOP_INSTR;
      if_id_pc_o <= '0;
    end else if (redirect_i) begin
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= NOP_INSTR;
    end else if (load) begin
      if_id_valid_o <= 1'b1;
      if_id_instr_o <= load_instr;
      if_id_pc_o <= load_pc;
    end else if (!stall_i) begin
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= NOP_INSTR;
    end
  end

  assign imem_req_o = (state == REQ);
  assign imem_addr_o = pc;
  assign opcode_o = if_id_instr_o[INSTR_W-1 -: 3];
  assign funct2_o = if_id_instr_o[INSTR_W-4 -: 2];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (load && perf_fetched_o != '1)
        perf_fetched_o <= perf_fetched_o + 32'd1;
      if (stall_i && if_id_valid_o && perf_stall_o != '1)
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a memory responder plus a scoreboard of
// expected IF/ID loads, checked with immediate assertions.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst, stall, redirect, ready, rvalid;
  logic [31:0] redirect_pc, rdata;

  logic req1, v1, req2, v2;
  logic [31:0] addr1, instr1, pc1, addr2, instr2, pc2;
  logic [2:0] op1, op2;
  logic [1:0] f21, f22;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf1, ps1, pf2, ps2;
`endif

  int total = 0;
  int bad = 0;
  logic [63:0] sbq[$];
  logic pend = 1'b0;
  logic pdead = 1'b0;
  logic [31:0] paddr = '0;
  int lat = 0;
  int cnt = 0;

  fetch_stage #(.NOP_INSTR(NOP)) u1 (
    .clk(clk), .rst(rst), .stall_i(stall),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req1), .imem_addr_o(addr1),
    .imem_ready_i(ready), .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata), .if_id_valid_o(v1),
    .if_id_instr_o(instr1), .if_id_pc_o(pc1),
    .opcode_o(op1), .funct2_o(f21)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched_o(pf1), .perf_stall_o(ps1)
`endif
  );

  fetch_stage #(.NOP_INSTR(NOP), .RESET_PC(32'hFFFF_FFFC)) u2 (
    .clk(clk), .rst(rst), .stall_i(stall),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ready_i(ready), .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata), .if_id_valid_o(v2),
    .if_id_instr_o(instr2), .if_id_pc_o(pc2),
    .opcode_o(op2), .funct2_o(f22)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched_o(pf2), .perf_stall_o(ps2)
`endif
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] ifn(input logic [31:0] a);
    logic [2:0] op;
    op = a[4:2] + 3'd1;
    return {op, a[3:2], a[26:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic acc, cons, ps, pv;
    logic [31:0] aa;
    logic [63:0] e;
    acc = req1 && ready;
    aa = addr1;
    cons = rvalid;
    ps = stall;
    pv = v1;
    chk("one_outstanding", 64'(acc && pend), 64'(0));
    if (cons && !(pdead || redirect))
      sbq.push_back({paddr, ifn(paddr)});
    if (!cons && pend && redirect) pdead = 1'b1;
    @(posedge clk);
    #1;
    if (cons) begin
      pend = 1'b0;
      rvalid = 1'b0;
      rdata = '0;
    end
    if (acc) begin
      pend = 1'b1;
      paddr = aa;
      pdead = redirect;
      cnt = lat;
    end
    if (pend && !rvalid) begin
      if (cnt == 0) begin
        rvalid = 1'b1;
        rdata = ifn(paddr);
      end else begin
        cnt--;
      end
    end
    if (v1 && (!ps || !pv)) begin
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'(1));
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("ifid_pc", 64'(pc1), 64'(e[63:32]));
        chk("ifid_instr", 64'(instr1), 64'(e[31:0]));
        chk("opcode", 64'(op1), 64'(e[31:29]));
        chk("funct2", 64'(f21), 64'(e[28:27]));
      end
    end else if (!v1) begin
      chk("bubble_nop", 64'(instr1), 64'(NOP));
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    ready = 1'b1;
    rvalid = 1'b0;
    rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(v1), 64'(0));
    chk("rst_instr", 64'(instr1), 64'(NOP));
    chk("rst_pc", 64'(pc1), 64'(0));
    chk("rst_req", 64'(req1), 64'(0));
    chk("rst_addr", 64'(addr1), 64'(0));
    chk("rst_addr2", 64'(addr2), 64'hFFFF_FFFC);
    chk("rst_valid2", 64'(v2 || req2), 64'(0));
    chk("rst_instr2", 64'(instr2), 64'(NOP));
    chk("rst_pc2", 64'(pc2), 64'(0));
    chk("rst_fields2", 64'({op2, f22}), 64'(0));
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf", 64'({pf1, ps1}), 64'(0));
    chk("rst_perf2", 64'({pf2, ps2}), 64'(0));
`endif
    rst = 1'b0;

    cyc();
    chk("first_req", 64'(req1), 64'(1));
    chk("first_addr", 64'(addr1), 64'(0));
    chk("first_addr2", 64'(addr2), 64'hFFFF_FFFC);
    cyc();
    chk("wait_no_req", 64'(req1), 64'(0));
    chk("pc_next", 64'(addr1), 64'(4));
    chk("pc_wrap", 64'(addr2), 64'(0));
    cyc();
    chk("first_valid", 64'(v1), 64'(1));
    chk("first_opcode", 64'(op1), 64'(3'b001));
    chk("first_funct2", 64'(f21), 64'(2'b00));
    chk("first_pc", 64'(pc1), 64'(0));
    chk("second_req", 64'({req1, addr1}), {31'(0), 1'b1, 32'(4)});
    repeat (2) cyc();
    chk("stream_pc4", 64'({v1, pc1}), {31'(0), 1'b1, 32'(4)});
    chk("stream_addr8", 64'(addr1), 64'(8));

    stall = 1'b1;
    cyc();
    cyc();
    chk("skid_no_req", 64'(req1), 64'(0));
    chk("skid_hold", 64'({v1, pc1}), {31'(0), 1'b1, 32'(4)});
    stall = 1'b0;
    cyc();
    chk("skid_load_pc8", 64'({v1, pc1}), {31'(0), 1'b1, 32'(8)});
    chk("after_skid_req", 64'({req1, addr1}), {31'(0), 1'b1, 32'(12)});
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_a", 64'(pf1), 64'(3));
    chk("perf_stall_a", 64'(ps1), 64'(2));
`endif

    lat = 1;
    cyc();
    redirect = 1'b1;
    redirect_pc = 32'h103;
    cyc();
    redirect = 1'b0;
    chk("redir_wait_hold", 64'({req1, addr1}), 64'(32'h100));
    cyc();
    chk("redir_wait_drop", 64'(v1), 64'(0));
    chk("redir_wait_req", 64'({req1, addr1}), {31'(0), 1'b1, 32'h100});
    lat = 0;
    repeat (2) cyc();
    chk("redir_target_load", 64'({v1, pc1}), {31'(0), 1'b1, 32'h100});
    chk("redir_target_next", 64'(addr1), 64'(32'h104));

    redirect = 1'b1;
    redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    chk("redir_ready_flush", 64'(v1), 64'(0));
    chk("redir_ready_wait", 64'(req1), 64'(0));
    cyc();
    chk("redir_ready_req", 64'({req1, addr1}), {31'(0), 1'b1, 32'h200});
    repeat (2) cyc();
    chk("redir_ready_load", 64'({v1, pc1}), {31'(0), 1'b1, 32'h200});

    stall = 1'b1;
    cyc();
    chk("stall_hold", 64'({v1, pc1}), {31'(0), 1'b1, 32'h200});
    redirect = 1'b1;
    redirect_pc = 32'h300;
    cyc();
    redirect = 1'b0;
    stall = 1'b0;
    chk("redir_stall_flush", 64'(v1), 64'(0));
    chk("redir_stall_req", 64'({req1, addr1}), {31'(0), 1'b1, 32'h300});
    repeat (2) cyc();
    chk("redir_stall_load", 64'({v1, pc1}), {31'(0), 1'b1, 32'h300});
    chk("redir_stall_next", 64'(addr1), 64'(32'h304));

    ready = 1'b0;
    cyc();
    chk("ready_low_hold", 64'({req1, addr1}), {31'(0), 1'b1, 32'h304});
    ready = 1'b1;
    chk("sb_drained", 64'(sbq.size()), 64'(0));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_b", 64'(pf1), 64'(6));
    chk("perf_stall_b", 64'(ps1), 64'(4));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
